// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    localparam int SLICE_W = 4;

    // Counter width able to hold WIDTH-1; never narrower than one bit.
    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/carry_select_subtractor.sv
// Combinational a - b (a + ~b + 1) built from SLICE_W-bit ripple slices with carry-select.
// carry_out is 1 when no borrow occurred (a >= b, unsigned).
module carry_select_subtractor
    import div_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             carry_out
);

    localparam int NS = (WIDTH + SLICE_W - 1) / SLICE_W;

    logic [WIDTH-1:0] b_n;
    logic [NS:0]      carry;

    assign b_n      = ~b;
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slice
            localparam int LO = gi * SLICE_W;
            // The top slice absorbs whatever is left when WIDTH is not a slice multiple.
            localparam int SW = (gi == NS - 1) ? (WIDTH - LO) : SLICE_W;

            if (gi == 0) begin : g_ripple
                assign {carry[gi+1], diff[LO +: SW]} =
                    {1'b0, a[LO +: SW]} + {1'b0, b_n[LO +: SW]} + {{SW{1'b0}}, carry[gi]};
            end else begin : g_select
                logic [SW:0] sum0;
                logic [SW:0] sum1;

                assign sum0 = {1'b0, a[LO +: SW]} + {1'b0, b_n[LO +: SW]};
                assign sum1 = {1'b0, a[LO +: SW]} + {1'b0, b_n[LO +: SW]} + (SW+1)'(1);
                assign {carry[gi+1], diff[LO +: SW]} = carry[gi] ? sum1 : sum0;
            end
        end
    endgenerate

    assign carry_out = carry[NS];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_ZERO_DETECT_EN: divisor 0 bypasses the iteration and flags div_zero.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = count_width(WIDTH);

    div_state_t       state_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;

    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   diff;
    logic             no_borrow;

    // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
    assign t_val = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    carry_select_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a         (t_val),
        .b         ({1'b0, d_reg}),
        .diff      (diff),
        .carry_out (no_borrow)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic dz_flag_reg;
    logic div_zero_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_flag_reg   <= 1'b0;
            div_zero_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        d_reg        <= divisor;
                        r_reg        <= '0;
                        q_reg        <= dividend;
                        count_reg    <= CW'(WIDTH - 1);
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
`ifdef DIV_ZERO_DETECT_EN
                        dz_flag_reg  <= (divisor == '0);
                        if (divisor == '0) begin
                            q_reg     <= '1;
                            r_reg     <= {1'b0, dividend};
                            state_reg <= DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    r_reg     <= no_borrow ? diff : t_val;
                    q_reg     <= {q_reg[WIDTH-2:0], no_borrow};
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == '0) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds until the handoff.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        quotient_reg  <= q_reg;
                        remainder_reg <= r_reg[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
                        div_zero_reg  <= dz_flag_reg;
`endif
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

`ifdef DIV_ZERO_DETECT_EN
    assign div_zero = div_zero_reg;
`else
    assign div_zero = 1'b0;
`endif

endmodule
